// File: rtl/axi4_read_arbiter.sv
// Two-requester AXI4 read arbiter onto a single memory read port.
// One outstanding read, round-robin on ties, sticky DATA-phase timeout flag.
module axi4_read_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int ADDR_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          s_arvalid,
  output logic [1:0]          s_arready,
  input  logic [2*ADDR_W-1:0] s_araddr,
  input  logic [5:0]          s_arprot,
  output logic [1:0]          s_rvalid,
  input  logic [1:0]          s_rready,
  output logic [63:0]         s_rdata,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [31:0]         m_rdata,
  output logic                grant_id,
  output logic                busy,
  output logic                timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              pick;
  logic              grant_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        prot_q;
  logic [15:0]       wait_cnt;
  logic [15:0]       wait_nxt;
  logic              err_nxt;
  logic              r_hs;

  // On a tie the requester that did not complete last wins.
  always_comb begin
    unique case (s_arvalid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant;
      default: pick = 1'b0;
    endcase
  end

  assign r_hs = (state == DATA) && m_rvalid
              && s_rready[grant_id];

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    wait_nxt  = wait_cnt;
    err_nxt   = timeout_err;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_arready = 2'b00;
    s_rvalid  = 2'b00;
    unique case (state)
      IDLE: begin
        if (|s_arvalid) begin
          state_nxt = ADDR;
          grant_nxt = pick;
        end
      end
      ADDR: begin
        m_arvalid           = 1'b1;
        s_arready[grant_id] = m_arready;
        if (m_arready) begin
          state_nxt = DATA;
          wait_nxt  = 16'd0;
        end
      end
      DATA: begin
        s_rvalid[grant_id] = m_rvalid;
        m_rready           = s_rready[grant_id];
        if (r_hs) begin
          state_nxt = IDLE;
        end else if (!m_rvalid) begin
          if (wait_cnt != 16'hFFFF) begin
            wait_nxt = wait_cnt + 16'd1;
          end
          if (wait_nxt >= TMO) begin
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant_id    <= 1'b0;
      last_grant  <= 1'b1;
      wait_cnt    <= 16'd0;
      timeout_err <= 1'b0;
      addr_q      <= '0;
      prot_q      <= 3'b000;
    end else begin
      state       <= state_nxt;
      grant_id    <= grant_nxt;
      wait_cnt    <= wait_nxt;
      timeout_err <= err_nxt;
      if (r_hs) begin
        last_grant <= grant_id;
      end
      // Capture the winner's fields so a dropped request keeps AR stable.
      if (state == IDLE && |s_arvalid) begin
        addr_q <= pick ? s_araddr[ADDR_W +: ADDR_W]
                       : s_araddr[0 +: ADDR_W];
        prot_q <= pick ? s_arprot[5:3] : s_arprot[2:0];
      end
    end
  end

  assign m_araddr = addr_q;
  assign m_arprot = prot_q;
  assign s_rdata  = {m_rdata, m_rdata};
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Scoreboard bench for axi4_read_arbiter: requester/memory agents,
// expected AR/R queues popped by an independent monitor.
module tb_axi4_read_arbiter;

  localparam int AW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    s_arvalid;
  logic [1:0]    s_arready;
  logic [63:0]   s_araddr;
  logic [5:0]    s_arprot;
  logic [1:0]    s_rvalid;
  logic [1:0]    s_rready;
  logic [63:0]   s_rdata;
  logic          m_arvalid;
  logic          m_arready;
  logic [AW-1:0] m_araddr;
  logic [2:0]    m_arprot;
  logic          m_rvalid;
  logic          m_rready;
  logic [31:0]   m_rdata;
  logic          grant_id;
  logic          busy;
  logic          timeout_err;

  axi4_read_arbiter #(
    .TIMEOUT(TMO),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_araddr   (s_araddr),
    .s_arprot   (s_arprot),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .s_rdata    (s_rdata),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_araddr   (m_araddr),
    .m_arprot   (m_arprot),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .m_rdata    (m_rdata),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } req_t;

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [2:0]  prot;
  } ar_t;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } r_t;

  req_t q0[$];
  req_t q1[$];
  ar_t  exp_ar[$];
  r_t   exp_r[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ar_delay = 0;
  int r_delay  = 0;
  int drop_after [2];
  int rr_hold [2];
  int ar_stall = 0;
  int r_stall  = 0;
  int n_ar_hs  = 0;
  bit outstanding [2];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no event expected one", name);
  endtask

  task automatic req(input bit id, input logic [31:0] a,
                     input logic [2:0] p);
    req_t r;
    r.addr = a;
    r.prot = p;
    if (id) q1.push_back(r);
    else    q0.push_back(r);
  endtask

  task automatic expect_txn(input bit id, input logic [31:0] a,
                            input logic [2:0] p,
                            input logic [31:0] d);
    ar_t e;
    r_t  f;
    e.id   = id;
    e.addr = a;
    e.prot = p;
    f.id   = id;
    f.data = d;
    exp_ar.push_back(e);
    exp_r.push_back(f);
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      done = exp_ar.size() == 0 && exp_r.size() == 0 && !busy
          && q0.size() == 0 && q1.size() == 0
          && !outstanding[0] && !outstanding[1];
    end
    if (!done) fail(name);
  endtask

  // Requester and memory agents: sample at negedge, drive after posedge.
  initial begin : agents
    logic [1:0]  sav;
    logic [1:0]  srv;
    logic [1:0]  srr;
    logic        mav;
    logic        mar;
    logic        mrv;
    logic        mrr;
    logic        gid;
    logic [31:0] maddr;
    logic [31:0] mdata;
    int          ar_wait;
    int          r_wait;
    bit          pend;
    int          hold [2];
    int          rrc [2];
    bit          dropped [2];
    ar_wait = 0;
    r_wait  = 0;
    pend    = 0;
    mdata   = 32'h0;
    for (int i = 0; i < 2; i++) begin
      hold[i] = 0;
      rrc[i] = 0;
      dropped[i] = 0;
      outstanding[i] = 0;
    end
    s_arvalid = 2'b00;
    s_araddr  = 64'h0;
    s_arprot  = 6'h0;
    s_rready  = 2'b00;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      sav   = s_arvalid;
      srv   = s_rvalid;
      srr   = s_rready;
      mav   = m_arvalid;
      mar   = m_arready;
      mrv   = m_rvalid;
      mrr   = m_rready;
      gid   = grant_id;
      maddr = m_araddr;
      @(posedge clk);
      #1;
      if (reset) begin
        ar_wait = 0;
        r_wait  = 0;
        pend    = 0;
        for (int i = 0; i < 2; i++) begin
          hold[i] = 0;
          rrc[i] = 0;
          dropped[i] = 0;
          outstanding[i] = 0;
        end
        s_arvalid = 2'b00;
        s_rready  = 2'b00;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
      end else begin
        if (mav && mar) begin
          pend    = 1;
          mdata   = {maddr[15:0], 16'hC0DE};
          r_wait  = 0;
          ar_wait = 0;
        end else if (mav) begin
          ar_wait++;
        end
        if (mrv && mrr) pend = 0;
        else if (pend && !mrv) r_wait++;
        m_arready = (ar_wait >= ar_delay);
        m_rvalid  = pend && (r_wait >= r_delay);
        m_rdata   = pend ? mdata : 32'h0;
        for (int i = 0; i < 2; i++) begin
          if (mav && mar && gid == 1'(i)) begin
            if (i == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            outstanding[i] = 1;
            dropped[i] = 0;
            hold[i] = 0;
          end else if (sav[i]) begin
            hold[i]++;
            if (drop_after[i] != 0 && hold[i] >= drop_after[i])
              dropped[i] = 1;
          end
          if (srv[i] && srr[i]) begin
            outstanding[i] = 0;
            rrc[i] = 0;
          end else if (srv[i]) begin
            rrc[i]++;
          end
          s_rready[i] = (rrc[i] >= rr_hold[i]);
        end
        s_arvalid[0] = q0.size() > 0 && !outstanding[0] && !dropped[0];
        s_arvalid[1] = q1.size() > 0 && !outstanding[1] && !dropped[1];
        if (q0.size() > 0) begin
          s_araddr[31:0] = q0[0].addr;
          s_arprot[2:0]  = q0[0].prot;
        end
        if (q1.size() > 0) begin
          s_araddr[63:32] = q1[0].addr;
          s_arprot[5:3]   = q1[0].prot;
        end
      end
    end
  end

  // Monitor: pops scoreboard on handshakes, checks routing every cycle.
  initial begin : monitor
    bit         prev_stall;
    int         wcnt;
    bit         err_m;
    ar_t        ea;
    r_t         er;
    logic [1:0] mask;
    prev_stall = 0;
    wcnt  = 0;
    err_m = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
        wcnt  = 0;
        err_m = 0;
      end else begin
        mask = grant_id ? 2'b10 : 2'b01;
        check("timeout_err", 64'(timeout_err), 64'(err_m));
        if (prev_stall)
          check("arvalid_hold", 64'(m_arvalid), 64'd1);
        if (!busy)
          check("idle_quiet",
                64'({m_arvalid, m_rready, s_arready, s_rvalid}), 64'd0);
        if (s_rvalid != 2'b00)
          check("rvalid_leak", 64'(s_rvalid & ~mask), 64'd0);
        if (m_rvalid)
          check("rready_pass", 64'(m_rready), 64'(s_rready[grant_id]));
        if (m_arvalid)
          check("arready_route", 64'(s_arready),
                64'(m_arready ? mask : 2'b00));
        if (m_arvalid && m_arready) begin
          n_ar_hs++;
          if (exp_ar.size() == 0) begin
            fail("ar_unexpected");
          end else begin
            ea = exp_ar.pop_front();
            check("ar_grant", 64'(grant_id), 64'(ea.id));
            check("ar_addr", 64'(m_araddr), 64'(ea.addr));
            check("ar_prot", 64'(m_arprot), 64'(ea.prot));
          end
          wcnt = 0;
        end else if (busy && !m_arvalid && !m_rvalid) begin
          wcnt++;
          if (wcnt >= TMO) err_m = 1;
        end
        if (m_arvalid && !m_arready) ar_stall++;
        if (m_rvalid && !m_rready) r_stall++;
        if ((s_rvalid & s_rready) != 2'b00) begin
          if (exp_r.size() == 0) begin
            fail("r_unexpected");
          end else begin
            er = exp_r.pop_front();
            check("r_id", 64'(s_rvalid[1]), 64'(er.id));
            check("r_data", s_rdata, {er.data, er.data});
          end
        end
        prev_stall = m_arvalid && !m_arready;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    int hs0;
    bit seen;
    drop_after[0] = 0;
    drop_after[1] = 0;
    rr_hold[0] = 0;
    rr_hold[1] = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_err", 64'(timeout_err), 64'd0);
    check("rst_outs",
          64'({m_arvalid, m_rready, s_arready, s_rvalid}), 64'd0);
    #2 reset = 1'b0;

    // Tie from reset: requester 0 first, then requester 1.
    @(negedge clk);
    expect_txn(1'b0, 32'h100, 3'b100, 32'h0100C0DE);
    expect_txn(1'b1, 32'h200, 3'b001, 32'h0200C0DE);
    req(1'b0, 32'h100, 3'b100);
    req(1'b1, 32'h200, 3'b001);
    @(posedge clk);
    #2;
    @(negedge clk);
    check("turn_req", 64'(s_arvalid), 64'd3);
    check("turn_idle", 64'(m_arvalid), 64'd0);
    @(negedge clk);
    check("turn_ar", 64'(m_arvalid), 64'd1);
    wait_idle(100, "t1_timeout");

    // Three back-to-back from 0, one from 1: order 0,1,0,0.
    expect_txn(1'b0, 32'h1000, 3'b100, 32'h1000C0DE);
    expect_txn(1'b1, 32'h2000, 3'b001, 32'h2000C0DE);
    expect_txn(1'b0, 32'h1004, 3'b100, 32'h1004C0DE);
    expect_txn(1'b0, 32'h1008, 3'b100, 32'h1008C0DE);
    req(1'b0, 32'h1000, 3'b100);
    req(1'b0, 32'h1004, 3'b100);
    req(1'b0, 32'h1008, 3'b100);
    req(1'b1, 32'h2000, 3'b001);
    wait_idle(200, "t2_timeout");

    // Slow AR ready with the request withdrawn early.
    ar_delay = 5;
    drop_after[0] = 2;
    base = ar_stall;
    hs0  = n_ar_hs;
    expect_txn(1'b0, 32'h3000, 3'b100, 32'h3000C0DE);
    req(1'b0, 32'h3000, 3'b100);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = m_arvalid;
    end
    if (!seen) fail("t3_arvalid");
    @(negedge clk);
    check("t3_dropped", 64'(s_arvalid[0]), 64'd0);
    check("t3_held", 64'(m_arvalid), 64'd1);
    wait_idle(100, "t3_timeout");
    check("t3_stall", 64'(ar_stall - base), 64'd5);
    check("t3_hs", 64'(n_ar_hs - hs0), 64'd1);
    ar_delay = 0;
    drop_after[0] = 0;

    // Requester back-pressures R for four cycles.
    rr_hold[0] = 4;
    base = r_stall;
    expect_txn(1'b0, 32'h4000, 3'b100, 32'h4000C0DE);
    req(1'b0, 32'h4000, 3'b100);
    wait_idle(100, "t4_timeout");
    check("t4_stall", 64'(r_stall - base), 64'd4);
    check("t4_idle", 64'(busy), 64'd0);
    rr_hold[0] = 0;

    // Data withheld for 20 cycles: sticky timeout, no abort.
    r_delay = 20;
    expect_txn(1'b0, 32'h5000, 3'b100, 32'h5000C0DE);
    req(1'b0, 32'h5000, 3'b100);
    wait_idle(100, "t5_timeout");
    r_delay = 0;
    repeat (3) @(negedge clk);
    check("t5_sticky", 64'(timeout_err), 64'd1);

    // Reset mid-DATA abandons the read; next tie goes to requester 0.
    r_delay = 50;
    expect_txn(1'b1, 32'h6000, 3'b001, 32'h6000C0DE);
    req(1'b1, 32'h6000, 3'b001);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = busy && !m_arvalid;
    end
    if (!seen) fail("t6_data");
    check("t6_grant", 64'(grant_id), 64'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_outs",
          64'({m_arvalid, m_rready, s_arready, s_rvalid}), 64'd0);
    check("t6_grant_rst", 64'(grant_id), 64'd0);
    check("t6_err_rst", 64'(timeout_err), 64'd0);
    exp_r.delete();
    r_delay = 0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    expect_txn(1'b0, 32'h7000, 3'b100, 32'h7000C0DE);
    expect_txn(1'b1, 32'h7100, 3'b001, 32'h7100C0DE);
    req(1'b0, 32'h7000, 3'b100);
    req(1'b1, 32'h7100, 3'b001);
    wait_idle(100, "t6_timeout");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_read_arbiter.md
AXI4_READ_ARBITER -- requirements
Module: axi4_read_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: cycles in DATA without m_rvalid before timeout_err sets; range 2..65535.
REQ-002 SHALL have parameter ADDR_W, default 32: address width of all ar channels.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_arvalid  input  2  per-requester read-address valid; bit i belongs to requester i (0 = instruction fetch, 1 = data/DMA).
REQ-006 SHALL have port s_arready  output  2  per-requester read-address ready.
REQ-007 SHALL have port s_araddr  input  2*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port s_arprot  input  6  packed prot; requester i uses bits [3*i +: 3].
REQ-009 SHALL have port s_rvalid  output  2  per-requester read-data valid.
REQ-010 SHALL have port s_rready  input  2  per-requester read-data ready.
REQ-011 SHALL have port s_rdata  output  64  read data; both 32-bit lanes carry m_rdata.
REQ-012 SHALL have port m_arvalid / m_arready / m_araddr / m_arprot  out / in / out / out  1 / 1 / ADDR_W / 3  shared memory read-address channel.
REQ-013 SHALL have port m_rvalid / m_rready / m_rdata  in / out / in  1 / 1 / 32  shared memory read-data channel.
REQ-014 SHALL have port grant_id  output  1  requester currently owning the channel.
REQ-015 SHALL have port busy  output  1  high in ADDR or DATA.
REQ-016 SHALL have port timeout_err  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE; exactly one outstanding read.
REQ-018 IDLE: if any s_arvalid bit is high, SHALL register grant_id and move to ADDR next edge; with no request, SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: with both bits high, grant the requester not granted last; a single request wins immediately.
REQ-020 last_grant SHALL update only on R handshake completion.
REQ-021 ADDR: m_arvalid=1, m_araddr/m_arprot = fields of grant_id, s_arready[grant_id]=m_arready, other s_arready bit 0.
REQ-022 ADDR: on m_arvalid&&m_arready, SHALL move to DATA; m_arvalid SHALL stay high until that handshake, even if the requester drops s_arvalid.
REQ-023 DATA: s_rvalid[grant_id]=m_rvalid, m_rready=s_rready[grant_id], other s_rvalid bit 0; on m_rvalid&&m_rready, SHALL return to IDLE.
REQ-024 In IDLE and ADDR, m_rready and both s_rvalid bits SHALL be 0; in IDLE and DATA, m_arvalid and both s_arready bits SHALL be 0.
REQ-025 Minimum turnaround SHALL be 1 IDLE cycle between transactions; a request at cycle N in IDLE SHALL see m_arvalid at N+1.
REQ-026 A 16-bit wait counter SHALL clear on DATA entry and increment each DATA cycle without m_rvalid.
REQ-027 timeout_err SHALL set when the counter reaches TIMEOUT and hold until reset; the FSM SHALL NOT abort (it keeps waiting).
REQ-028 grant_id SHALL hold its value from ADDR entry through DATA exit; busy = (state != IDLE).

Reset
REQ-029 While reset is high: state=IDLE, grant_id=0, last_grant=1 (requester 0 wins the first tie), wait counter=0, timeout_err=0, and all valid/ready outputs 0.
REQ-030 Reset asserted mid-ADDR or mid-DATA SHALL immediately drop m_arvalid/m_rready/s_* outputs; the in-flight transaction is abandoned.

Verification
REQ-031 Both s_arvalid high from reset, addrs 0x100 / 0x200, memory ready immediately -> requester 0 served first (m_araddr=0x100), then requester 1 (0x200); grant_id 0 then 1.
REQ-032 Requester 0 issues 3 back-to-back reads, requester 1 issues 1 concurrently -> order is 0,1,0,0; no s_rvalid ever reaches the non-granted requester.
REQ-033 m_arready delayed 5 cycles, s_arvalid dropped after 2 -> m_arvalid held high all 5 cycles; exactly one AR handshake; transaction completes.
REQ-034 s_rready[grant]=0 for 4 cycles with m_rvalid=1 -> m_rready=0 for those cycles; completes on the first cycle s_rready=1; state returns to IDLE.
REQ-035 TIMEOUT=8, m_rvalid withheld 20 cycles -> timeout_err rises after 8 DATA wait cycles, stays 1 after completion; cleared only by reset.
REQ-036 reset pulsed during DATA -> outputs 0 within the same cycle (async); next request after release is granted to requester 0.
